vga_text_scanout: RTL and testbench

- Text-mode VGA scanout controller.
- Generates 640x480@60 raster timing from the pixel clock.
- Fetches character codes from an external synchronous text RAM and sequences the glyph ROM (char code, scanline, column) to produce a 1-bit pixel stream.
- Overlays a blinking underline cursor.
- Sits between the text-buffer RAM, the glyph ROM and the VGA DAC/sync pins.

---
 rtl/vga_text_scanout_if.sv | 30 +++
 rtl/vga_text_scanout.sv | 159 +++++++++++++++
 tb/tb_vga_text_scanout.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_text_scanout_if.sv
// Scanout engine <-> text RAM, glyph ROM, cursor source and VGA pins.
// master = scanout engine, slave = memories, cursor source and display.
interface vga_text_scanout_if;
    logic [11:0] text_addr;
    logic [7:0]  text_data;
    logic [7:0]  char_code;
    logic [3:0]  glyph_row;
    logic [2:0]  glyph_col;
    logic        glyph_bit;
    logic        cursor_en;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        pixel;
    logic        frame_start;

    modport master (
        output text_addr, char_code, glyph_row, glyph_col,
        output hsync, vsync, de, pixel, frame_start,
        input  text_data, glyph_bit, cursor_en, cursor_x, cursor_y
    );

    modport slave (
        input  text_addr, char_code, glyph_row, glyph_col,
        input  hsync, vsync, de, pixel, frame_start,
        output text_data, glyph_bit, cursor_en, cursor_x, cursor_y
    );
endinterface

// File: rtl/vga_text_scanout.sv
// Text-mode VGA scanout with blinking underline cursor; 3 clk_in from counter position to every pin.
// Free-running raster: no backpressure, the RAM and ROM must answer at the stated latency.
module vga_text_scanout #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int COLS         = H_ACTIVE / 8,
    parameter int ROWS         = V_ACTIVE / 16,
    parameter int BLINK_FRAMES = 32
) (
    input  logic               clk_in,
    input  logic               reset_in,
    vga_text_scanout_if.master bus
);
    localparam logic [9:0]  H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0]  HS_BEG     = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG     = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] ROW_STEP   = 12'(COLS);
    localparam logic [6:0]  COL_LIM    = 7'(COLS);
    localparam logic [4:0]  ROW_LIM    = 5'(ROWS);
    localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [9:0]  h_cnt, v_cnt;
    logic [11:0] row_base;
    logic [7:0]  blink_cnt;
    logic        blink_phase;
    logic        sh_en;
    logic [6:0]  sh_x;
    logic [4:0]  sh_y;

    logic        h_last, v_last, act0, hs0, vs0, first0;
    logic [11:0] addr0;

    logic [11:0] s1_addr;
    logic [3:0]  s1_row, s2_row;
    logic [2:0]  s1_col, s2_col;
    logic [6:0]  s1_cx, s2_cx;
    logic [4:0]  s1_cy, s2_cy;
    logic        s1_act, s2_act, s1_hs, s2_hs, s1_vs, s2_vs, s1_fs, s2_fs;
    logic        cursor_hit;
    logic        pix_r, de_r, hsync_r, vsync_r, fs_r;

    always_comb begin
        h_last = (h_cnt == H_LAST);
        v_last = (v_cnt == V_LAST);
        act0   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs0    = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        vs0    = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
        first0 = act0 && (h_cnt == 10'd0) && (v_cnt == 10'd0);
        addr0  = act0 ? (row_base + {5'd0, h_cnt[9:3]}) : 12'd0;
    end

    // The range checks keep stale or bogus cursor coordinates from matching blanking cells.
    assign cursor_hit = sh_en && blink_phase && (sh_x < COL_LIM) && (sh_y < ROW_LIM)
                        && (s2_cx == sh_x) && (s2_cy == sh_y) && (s2_row >= 4'd14);

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            row_base    <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            sh_en       <= 1'b0;
            sh_x        <= '0;
            sh_y        <= '0;
            s1_addr     <= '0;
            s1_row      <= '0;
            s1_col      <= '0;
            s1_cx       <= '0;
            s1_cy       <= '0;
            s1_act      <= 1'b0;
            s1_hs       <= 1'b0;
            s1_vs       <= 1'b0;
            s1_fs       <= 1'b0;
            s2_row      <= '0;
            s2_col      <= '0;
            s2_cx       <= '0;
            s2_cy       <= '0;
            s2_act      <= 1'b0;
            s2_hs       <= 1'b0;
            s2_vs       <= 1'b0;
            s2_fs       <= 1'b0;
            pix_r       <= 1'b0;
            de_r        <= 1'b0;
            hsync_r     <= 1'b1;
            vsync_r     <= 1'b1;
            fs_r        <= 1'b0;
        end else begin
            h_cnt <= h_last ? 10'd0 : h_cnt + 10'd1;
            if (h_last) begin
                v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
                // row_base tracks char_row*COLS by stepping after each cell's last scanline.
                if (v_last)
                    row_base <= '0;
                else if ((v_cnt < V_ACT) && (v_cnt[3:0] == 4'hF))
                    row_base <= row_base + ROW_STEP;
                if (v_last) begin
                    if (blink_cnt == BLINK_LAST) begin
                        blink_cnt   <= '0;
                        blink_phase <= ~blink_phase;
                    end else begin
                        blink_cnt <= blink_cnt + 8'd1;
                    end
                end
            end
            if ((h_cnt == 10'd0) && (v_cnt == 10'd0)) begin
                sh_en <= bus.cursor_en;
                sh_x  <= bus.cursor_x;
                sh_y  <= bus.cursor_y;
            end

            s1_addr <= addr0;
            s1_row  <= v_cnt[3:0];
            s1_col  <= h_cnt[2:0];
            s1_cx   <= h_cnt[9:3];
            s1_cy   <= v_cnt[8:4];
            s1_act  <= act0;
            s1_hs   <= hs0;
            s1_vs   <= vs0;
            s1_fs   <= first0;

            s2_row  <= s1_row;
            s2_col  <= s1_col;
            s2_cx   <= s1_cx;
            s2_cy   <= s1_cy;
            s2_act  <= s1_act;
            s2_hs   <= s1_hs;
            s2_vs   <= s1_vs;
            s2_fs   <= s1_fs;

            pix_r   <= s2_act & (bus.glyph_bit ^ cursor_hit);
            de_r    <= s2_act;
            hsync_r <= ~s2_hs;
            vsync_r <= ~s2_vs;
            fs_r    <= s2_fs;
        end
    end

    assign bus.text_addr   = s1_addr;
    assign bus.char_code   = s2_act ? bus.text_data : 8'h00;
    assign bus.glyph_row   = s2_row;
    assign bus.glyph_col   = s2_col;
    assign bus.pixel       = pix_r;
    assign bus.de          = de_r;
    assign bus.hsync       = hsync_r;
    assign bus.vsync       = vsync_r;
    assign bus.frame_start = fs_r;
endmodule

// File: tb/tb_vga_text_scanout.sv
// Directed bench on a shrunken raster: 80 clocks/line (64 active, hsync 68..75), 55 lines/frame
// (48 active, vsync lines 50..51), 8x3 cells, cursor blink phase flips every 2 frames.
module tb_vga_text_scanout;
    localparam int FRAME = 80 * 55;

    logic clk_in = 1'b0;
    logic reset_in = 1'b0;
    logic ram_const = 1'b0;
    logic rom_blank = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    int   pos = 0;

    always #5 clk_in = ~clk_in;

    vga_text_scanout_if bus ();

    vga_text_scanout #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .COLS(8), .ROWS(3), .BLINK_FRAMES(2)
    ) dut (
        .clk_in  (clk_in),
        .reset_in(reset_in),
        .bus     (bus)
    );

    // Synchronous text RAM: either a fixed 'A' or the low address byte as the character.
    always @(posedge clk_in) bus.text_data <= ram_const ? 8'h41 : bus.text_addr[7:0];

    always_comb bus.glyph_bit = !rom_blank && (bus.glyph_col == 3'd3);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // pos = raster position whose pixel/sync/de are on the pins; text_addr shows pos+2, glyph bus pos+1.
    task automatic wait_pos(input int p);
        while (pos < p) begin
            @(posedge clk_in);
            pos++;
        end
        #1;
    endtask

    task automatic grab(input int p0, output logic [7:0] b);
        b = '0;
        for (int i = 0; i < 8; i++) begin
            wait_pos(p0 + i);
            b = {b[6:0], bus.pixel};
        end
    endtask

    initial begin
        logic [7:0] b;
        int hs_low, vs_low, de_cnt, fs_cnt, pix_cnt, pix_bad, run, run_min, run_max, addr_max;
        int first, last, cnt;

        bus.cursor_en = 1'b0;
        bus.cursor_x  = 7'd0;
        bus.cursor_y  = 5'd0;

        repeat (5) @(posedge clk_in);
        #1;
        check("rst_hsync", bus.hsync, 1);
        check("rst_vsync", bus.vsync, 1);
        check("rst_de", bus.de, 0);
        check("rst_pixel", bus.pixel, 0);
        check("rst_addr", bus.text_addr, 0);
        check("rst_fs", bus.frame_start, 0);
        check("rst_char", bus.char_code, 0);
        check("rst_grow", bus.glyph_row, 0);
        check("rst_gcol", bus.glyph_col, 0);

        // ---- frame 0: latency, sync edges, addressing (RAM returns address) ----
        reset_in = 1'b1;
        pos = -3;
        wait_pos(-2);
        check("refill_de_1", bus.de, 0);
        check("first_addr", bus.text_addr, 0);
        wait_pos(-1);
        check("refill_de_2", bus.de, 0);
        wait_pos(0);
        check("first_de", bus.de, 1);
        check("first_fs", bus.frame_start, 1);
        check("first_hsync", bus.hsync, 1);
        check("first_pixel", bus.pixel, 0);
        wait_pos(1);
        check("fs_one_cycle", bus.frame_start, 0);
        wait_pos(3);
        check("glyph_col3_on", bus.pixel, 1);
        wait_pos(4);
        check("glyph_col4_off", bus.pixel, 0);
        wait_pos(63);
        check("de_last_active", bus.de, 1);
        wait_pos(64);
        check("de_blank", bus.de, 0);
        wait_pos(67);
        check("hsync_pre", bus.hsync, 1);
        wait_pos(68);
        check("hsync_start", bus.hsync, 0);
        wait_pos(75);
        check("hsync_end", bus.hsync, 0);
        wait_pos(76);
        check("hsync_post", bus.hsync, 1);
        wait_pos(1278);
        check("addr_v16_h0", bus.text_addr, 8);
        wait_pos(1285);
        check("addr_v16_h7", bus.text_addr, 8);
        wait_pos(1286);
        check("addr_v16_h8", bus.text_addr, 9);
        wait_pos(1287);
        check("char_v16_h8", bus.char_code, 9);
        check("grow_v16_h8", bus.glyph_row, 0);
        check("gcol_v16_h8", bus.glyph_col, 0);
        wait_pos(1293);
        check("addr_v16_h15", bus.text_addr, 9);
        wait_pos(1692);
        check("char_v21_h13", bus.char_code, 9);
        check("grow_v21_h13", bus.glyph_row, 5);
        check("gcol_v21_h13", bus.glyph_col, 5);
        wait_pos(3821);
        check("addr_last_cell", bus.text_addr, 23);
        wait_pos(3822);
        check("char_last_cell", bus.char_code, 23);
        check("grow_last_cell", bus.glyph_row, 15);
        check("gcol_last_cell", bus.glyph_col, 7);
        check("addr_hblank", bus.text_addr, 0);
        wait_pos(3840);
        check("de_vblank", bus.de, 0);
        check("pix_vblank", bus.pixel, 0);
        wait_pos(3999);
        check("vsync_pre", bus.vsync, 1);
        wait_pos(4000);
        check("vsync_start", bus.vsync, 0);
        wait_pos(4159);
        check("vsync_end", bus.vsync, 0);
        wait_pos(4160);
        check("vsync_post", bus.vsync, 1);

        // ---- frame 1: whole-frame totals; cursor (1,0) armed for frame 2 ----
        hs_low = 0; vs_low = 0; de_cnt = 0; fs_cnt = 0; pix_cnt = 0; pix_bad = 0;
        run = 0; run_min = 1000; run_max = 0; addr_max = 0;
        for (int p = FRAME; p < 2 * FRAME; p++) begin
            wait_pos(p);
            if (p == FRAME + 100) begin
                bus.cursor_en = 1'b1;
                bus.cursor_x  = 7'd1;
                bus.cursor_y  = 5'd0;
            end
            if (p == 2 * FRAME - 100) ram_const = 1'b1;
            if (!bus.hsync) hs_low++;
            if (!bus.vsync) vs_low++;
            if (bus.de) de_cnt++;
            if (bus.frame_start) fs_cnt++;
            if (bus.pixel) pix_cnt++;
            if (bus.pixel && !bus.de) pix_bad++;
            if (int'(bus.text_addr) > addr_max) addr_max = int'(bus.text_addr);
            if (!bus.hsync) run++;
            else if (run != 0) begin
                if (run > run_max) run_max = run;
                if (run < run_min) run_min = run;
                run = 0;
            end
        end
        check("f1_hsync_low", hs_low, 440);
        check("f1_vsync_low", vs_low, 160);
        check("f1_de_cycles", de_cnt, 3072);
        check("f1_fs_pulses", fs_cnt, 1);
        check("f1_hs_run_max", run_max, 8);
        check("f1_hs_run_min", run_min, 8);
        check("f1_addr_max", addr_max, 23);
        check("f1_pixels", pix_cnt, 384);
        check("f1_pix_no_de", pix_bad, 0);

        // ---- frame 2: glyph path with 'A', cursor XOR at cell (1,0), no tearing ----
        wait_pos(2 * FRAME + 160);
        bus.cursor_x = 7'd5;
        bus.cursor_y = 5'd2;
        wait_pos(2 * FRAME + 249);
        check("f2_char", bus.char_code, 8'h41);
        check("f2_grow", bus.glyph_row, 3);
        check("f2_gcol", bus.glyph_col, 2);
        grab(2 * FRAME + 5 * 80 + 8, b);
        check("f2_row5_cell1", b, 8'b0001_0000);
        grab(2 * FRAME + 14 * 80, b);
        check("f2_row14_cell0", b, 8'b0001_0000);
        grab(2 * FRAME + 14 * 80 + 8, b);
        check("f2_row14_cursor", b, 8'b1110_1111);
        grab(2 * FRAME + 14 * 80 + 40, b);
        check("f2_no_tear", b, 8'b0001_0000);
        grab(2 * FRAME + 15 * 80 + 8, b);
        check("f2_row15_cursor", b, 8'b1110_1111);
        wait_pos(2 * FRAME + 4000);
        rom_blank = 1'b1;

        // ---- frame 3: blank glyphs, cursor (5,2) visible; frame 4: blink off ----
        first = -1; last = -1; cnt = 0;
        for (int p = 3 * FRAME; p < 4 * FRAME; p++) begin
            wait_pos(p);
            if (bus.pixel) begin
                if (first < 0) first = p;
                last = p;
                cnt++;
            end
        end
        check("f3_cursor_pixels", cnt, 16);
        check("f3_cursor_first", first, 3 * FRAME + 46 * 80 + 40);
        check("f3_cursor_last", last, 3 * FRAME + 47 * 80 + 47);
        cnt = 0;
        for (int p = 4 * FRAME; p < 5 * FRAME; p++) begin
            wait_pos(p);
            if (bus.pixel) cnt++;
        end
        check("f4_blink_off", cnt, 0);
        grab(6 * FRAME + 46 * 80 + 40, b);
        check("f6_blink_on", b, 8'hFF);

        // ---- frame 7: one-cycle reset in the middle of an hsync pulse ----
        wait_pos(7 * FRAME + 20 * 80 + 70);
        check("pre_rst_hsync", bus.hsync, 0);
        reset_in = 1'b0;
        @(posedge clk_in);
        #1;
        check("mid_rst_hsync", bus.hsync, 1);
        check("mid_rst_de", bus.de, 0);
        check("mid_rst_addr", bus.text_addr, 0);
        check("mid_rst_pixel", bus.pixel, 0);
        reset_in = 1'b1;
        pos = -3;
        wait_pos(-2);
        check("rr_addr0", bus.text_addr, 0);
        check("rr_de_1", bus.de, 0);
        wait_pos(-1);
        check("rr_de_2", bus.de, 0);
        wait_pos(0);
        check("rr_first_de", bus.de, 1);
        check("rr_first_fs", bus.frame_start, 1);
        wait_pos(6);
        check("rr_addr_cell1", bus.text_addr, 1);
        first = -1; cnt = 0;
        for (int p = 7; p < 80; p++) begin
            wait_pos(p);
            if (!bus.hsync) begin
                if (first < 0) first = p;
                cnt++;
            end
        end
        check("rr_hsync_start", first, 68);
        check("rr_hsync_len", cnt, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
